// File: rtl/lc3_ctrl_fsm.sv
// lc3_ctrl_fsm: LC3 instruction sequencer.
// Steps one instruction at a time through fetch, decode, execute, memory, writeback and PC update.
module lc3_ctrl_fsm #(
  parameter int unsigned FETCH_LAT = 2,
  parameter logic [7:0]  HALT_VECT = 8'h25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] instr_in,
  input  logic        mem_ready,
  output logic        fetch_start,
  output logic [3:0]  opCode_out,
  output logic [8:0]  offset_out,
  output logic [2:0]  br_nzp,
  output logic [15:0] ir,
  output logic        dec_en,
  output logic        exe_en,
  output logic        mem_en,
  output logic        mem_we,
  output logic        wb_en,
  output logic        nzp_en,
  output logic        busy,
  output logic        halted,
  output logic [3:0]  state_out
);

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  localparam logic [3:0] LAST_CNT = 4'(FETCH_LAT - 1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_EXECUTE = 4'd3,
    S_MEM1    = 4'd4,
    S_MEM2    = 4'd5,
    S_WB      = 4'd6,
    S_PC_UPD  = 4'd7,
    S_HALT    = 4'd8
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [3:0] fcnt;
  logic       fetch_last;
  logic       ir_load;
  logic [3:0] op;

  logic       is_ld_dir;
  logic       is_st_dir;
  logic       is_ldi;
  logic       is_sti;
  logic       is_mem;
  logic       is_alu;
  logic       is_halt;

  assign op         = ir[15:12];
  assign fetch_last = (fcnt == LAST_CNT);
  assign ir_load    = (state == S_FETCH) && fetch_last;

  // Opcode classes; everything else (BR, JMP, JSR, RTI, 1101, other TRAPs)
  // falls through to a plain PC update.
  always_comb begin
    is_ld_dir = (op == OP_LD) || (op == OP_LDR);
    is_st_dir = (op == OP_ST) || (op == OP_STR);
    is_ldi    = (op == OP_LDI);
    is_sti    = (op == OP_STI);
    is_mem    = is_ld_dir || is_st_dir || is_ldi || is_sti;
    is_alu    = (op == OP_ADD) || (op == OP_AND) ||
                (op == OP_NOT) || (op == OP_LEA);
    is_halt   = (op == OP_TRAP) && (ir[7:0] == HALT_VECT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      fcnt       <= '0;
      ir         <= '0;
      opCode_out <= '0;
      offset_out <= '0;
      br_nzp     <= '0;
    end else begin
      state <= state_nx;
      if ((state == S_FETCH) && !fetch_last) begin
        fcnt <= fcnt + 4'd1;
      end else begin
        fcnt <= '0;
      end
      if (ir_load) begin
        ir         <= instr_in;
        opCode_out <= instr_in[15:12];
        offset_out <= instr_in[8:0];
        br_nzp     <= instr_in[11:9];
      end
    end
  end

  always_comb begin
    state_nx    = state;
    fetch_start = 1'b0;
    dec_en      = 1'b0;
    exe_en      = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    wb_en       = 1'b0;
    nzp_en      = 1'b0;
    busy        = 1'b1;
    halted      = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nx = S_FETCH;
        end
      end
      S_FETCH: begin
        if (fetch_last) begin
          state_nx = S_DECODE;
        end
      end
      S_DECODE: begin
        dec_en   = 1'b1;
        state_nx = S_EXECUTE;
      end
      S_EXECUTE: begin
        exe_en = 1'b1;
        unique case (1'b1)
          is_mem:  state_nx = S_MEM1;
          is_alu:  state_nx = S_WB;
          is_halt: state_nx = S_HALT;
          default: state_nx = S_PC_UPD;
        endcase
      end
      S_MEM1: begin
        // For STI this access is the pointer read, hence no write.
        mem_en = 1'b1;
        mem_we = is_st_dir;
        if (mem_ready) begin
          unique case (1'b1)
            is_ldi || is_sti: state_nx = S_MEM2;
            is_ld_dir:        state_nx = S_WB;
            default:          state_nx = S_PC_UPD;
          endcase
        end
      end
      S_MEM2: begin
        mem_en = 1'b1;
        mem_we = is_sti;
        if (mem_ready) begin
          state_nx = is_sti ? S_PC_UPD : S_WB;
        end
      end
      S_WB: begin
        wb_en    = 1'b1;
        nzp_en   = 1'b1;
        state_nx = S_PC_UPD;
      end
      S_PC_UPD: begin
        fetch_start = 1'b1;
        state_nx    = S_FETCH;
      end
      S_HALT: begin
        busy   = 1'b0;
        halted = 1'b1;
      end
      default: begin
        busy     = 1'b0;
        state_nx = S_IDLE;
      end
    endcase
  end

  assign state_out = state;

endmodule

// File: tb/tb_lc3_ctrl_fsm.sv
// tb_lc3_ctrl_fsm: scoreboard bench for the LC3 sequencer.
// Instructions are issued with a per-instruction expectation; a monitor checks each completion.
module tb_lc3_ctrl_fsm;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] instr_in;
  logic        mem_ready = 1'b0;
  logic        fetch_start;
  logic [3:0]  opCode_out;
  logic [8:0]  offset_out;
  logic [2:0]  br_nzp;
  logic [15:0] ir;
  logic        dec_en;
  logic        exe_en;
  logic        mem_en;
  logic        mem_we;
  logic        wb_en;
  logic        nzp_en;
  logic        busy;
  logic        halted;
  logic [3:0]  state_out;

  lc3_ctrl_fsm #(.FETCH_LAT(L), .HALT_VECT(8'h25)) dut (
    .clk(clk), .rst(rst), .start(start), .instr_in(instr_in),
    .mem_ready(mem_ready), .fetch_start(fetch_start),
    .opCode_out(opCode_out), .offset_out(offset_out), .br_nzp(br_nzp),
    .ir(ir), .dec_en(dec_en), .exe_en(exe_en), .mem_en(mem_en),
    .mem_we(mem_we), .wb_en(wb_en), .nzp_en(nzp_en), .busy(busy),
    .halted(halted), .state_out(state_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ins;
    int          lat;
    int          memc;
    int          wec;
    int          wbc;
    bit          halt;
  } exp_t;

  exp_t exp_q[$];
  int   dly_q[$];
  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic finish_tb();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  // Reference: classify by opcode and add up the phases each class visits.
  function automatic exp_t model(logic [15:0] ins, int d1, int d2);
    exp_t e;
    int op;
    op     = int'(ins[15:12]);
    e.ins  = ins;
    e.halt = 1'b0;
    e.memc = 0;
    e.wec  = 0;
    e.wbc  = 0;
    case (op)
      1, 5, 9, 14: e.wbc = 1;
      2, 6: begin e.memc = d1 + 1; e.wbc = 1; end
      3, 7: begin e.memc = d1 + 1; e.wec = d1 + 1; end
      10: begin e.memc = d1 + d2 + 2; e.wbc = 1; end
      11: begin e.memc = d1 + d2 + 2; e.wec = d2 + 1; end
      15: e.halt = (ins[7:0] == 8'h25);
      default: ;
    endcase
    e.lat = e.halt ? L + 2 : L + 2 + e.memc + e.wbc + 1;
    return e;
  endfunction

  task automatic issue(logic [15:0] ins, int d1, int d2);
    int op;
    op = int'(ins[15:12]);
    exp_q.push_back(model(ins, d1, d2));
    if (op inside {2, 3, 6, 7}) dly_q.push_back(d1);
    if (op inside {10, 11}) begin
      dly_q.push_back(d1);
      dly_q.push_back(d2);
    end
    instr_in = ins;
  endtask

  task automatic wait_done();
    int base;
    int n;
    base = done_cnt;
    n = 0;
    while (done_cnt == base && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == base) begin
      tests++;
      fails++;
      $display("FAIL timeout: no completion for ir=%0h after %0d cycles", instr_in, n);
      finish_tb();
    end
  endtask

  // Memory responder: each access waits its queued delay, then pulses mem_ready.
  bit active = 1'b0;
  int acc = 0;
  int dcur = 0;
  always @(negedge clk) begin
    mem_ready = 1'b0;
    if (rst || !mem_en) begin
      active = 1'b0;
    end else begin
      if (!active) begin
        active = 1'b1;
        acc = 0;
        dcur = (dly_q.size() != 0) ? dly_q.pop_front() : 0;
      end
      if (acc == dcur) begin
        mem_ready = 1'b1;
        active = 1'b0;
      end else begin
        acc++;
      end
    end
  end

  int   cyc, nd, ne, nw, nn, nm, nwe;
  logic halted_q = 1'b0;
  exp_t e;
  always @(negedge clk) begin
    if (rst) begin
      cyc = 0; nd = 0; ne = 0; nw = 0; nn = 0; nm = 0; nwe = 0;
      halted_q = 1'b0;
    end else begin
      if (busy) cyc++;
      nd  += int'(dec_en);
      ne  += int'(exe_en);
      nw  += int'(wb_en);
      nn  += int'(nzp_en);
      nm  += int'(mem_en);
      nwe += int'(mem_en & mem_we);
      if (fetch_start || (halted && !halted_q)) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_event: fetch_start=%0b halted=%0b", fetch_start, halted);
        end else begin
          e = exp_q.pop_front();
          chk("halt_kind", 32'(halted), 32'(e.halt));
          chk("ir", 32'(ir), 32'(e.ins));
          if (!e.halt) begin
            chk("opcode", 32'(opCode_out), 32'(e.ins[15:12]));
            chk("offset", 32'(offset_out), 32'(e.ins[8:0]));
            chk("br_nzp", 32'(br_nzp), 32'(e.ins[11:9]));
          end
          chk("latency", 32'(cyc), 32'(e.lat));
          chk("dec_cnt", 32'(nd), 32'd1);
          chk("exe_cnt", 32'(ne), 32'd1);
          chk("mem_cycles", 32'(nm), 32'(e.memc));
          chk("we_cycles", 32'(nwe), 32'(e.wec));
          chk("wb_cnt", 32'(nw), 32'(e.wbc));
          chk("nzp_cnt", 32'(nn), 32'(e.wbc));
        end
        done_cnt++;
        cyc = 0; nd = 0; ne = 0; nw = 0; nn = 0; nm = 0; nwe = 0;
      end
      halted_q = halted;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    fails++;
    finish_tb();
  end

  initial begin
    logic [15:0] ins;
    int n;
    rst = 1'b1;
    start = 1'b1;
    instr_in = 16'hC1C0;
    repeat (5) @(negedge clk);
    chk("rst_state", 32'(state_out), 32'd0);
    chk("rst_fetch_start", 32'(fetch_start), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_wb_en", 32'(wb_en), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_opcode", 32'(opCode_out), 32'd0);
    chk("rst_offset", 32'(offset_out), 32'd0);
    chk("rst_ir", 32'(ir), 32'd0);

    rst = 1'b0;
    issue(16'h1261, 0, 0);
    wait_done();
    issue(16'hC1C0, 0, 0);
    wait_done();
    issue(16'hA405, 3, 3);
    wait_done();
    issue(16'hB405, 1, 1);
    wait_done();

    for (int i = 0; i < 60; i++) begin
      ins = 16'($urandom);
      if (ins[15:12] == 4'hF && ins[7:0] == 8'h25) ins[0] = 1'b0;
      start = 1'($urandom_range(0, 1));
      issue(ins, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      wait_done();
    end

    issue(16'hF025, 0, 0);
    wait_done();
    for (int i = 0; i < 6; i++) begin
      start = 1'(i % 2);
      @(negedge clk);
      chk("halt_state", 32'(state_out), 32'd8);
      chk("halt_busy", 32'(busy), 32'd0);
      chk("halt_fetch", 32'(fetch_start), 32'd0);
    end

    rst = 1'b1;
    @(negedge clk);
    chk("rst_from_halt", 32'(state_out), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    dly_q.delete();
    start = 1'b1;
    instr_in = 16'h2405;
    dly_q.push_back(50);
    n = 0;
    while (state_out != 4'd4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("reach_mem1", 32'(state_out), 32'd4);
    @(negedge clk);
    chk("mem1_mem_en", 32'(mem_en), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midmem_state", 32'(state_out), 32'd0);
    chk("midmem_mem_en", 32'(mem_en), 32'd0);
    chk("midmem_ir", 32'(ir), 32'd0);
    chk("midmem_opcode", 32'(opCode_out), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    finish_tb();
  end

endmodule
